// File: rtl/lbp_param.sv
// Local-history branch predictor: per-PC history table (BHT) feeding a table of saturating counters (PHT).
// Latency: prediction registered 1 cycle after IF_PC; training writes land on the same edge, visible next edge.
// Backpressure: none; one lookup and one update accepted every cycle, Ready low during the post-reset clear walk.
//
// Ports:
//   CLK        rising-edge clock
//   RESET      synchronous active-low reset; restarts the clear walk
//   IF_PC      fetch PC to predict, BHT index = IF_PC[IDX_BITS+1:2]
//   ID_PC      PC of the branch resolved in ID, same indexing
//   Is_Branch  qualifies the ID update
//   Is_Taken   resolved direction (don't-care when Is_Branch=0)
//   pred       registered taken prediction (counter MSB)
//   Ready      tables initialised
module lbp_param #(
    parameter int HIST_BITS = 10,
    parameter int IDX_BITS  = 10,
    parameter int CTR_BITS  = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IF_PC,
    input  logic [31:0] ID_PC,
    input  logic        Is_Branch,
    input  logic        Is_Taken,
    output logic        pred,
    output logic        Ready
);

    // The clear walk covers the deeper of the two tables; both depths are
    // powers of two, so the walk counter is simply the wider index.
    localparam int CLR_W     = (IDX_BITS > HIST_BITS) ? IDX_BITS : HIST_BITS;
    localparam int BHT_DEPTH = 1 << IDX_BITS;
    localparam int PHT_DEPTH = 1 << HIST_BITS;

    localparam logic [31:0] BHT_DEPTH_U = BHT_DEPTH;
    localparam logic [31:0] PHT_DEPTH_U = PHT_DEPTH;

    // Weakly not-taken: MSB clear, all lower bits set.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t               state;
    logic [CLR_W-1:0]     clr;

    logic [HIST_BITS-1:0] bht [BHT_DEPTH];
    logic [CTR_BITS-1:0]  pht [PHT_DEPTH];

    logic [IDX_BITS-1:0]  if_idx;
    logic [IDX_BITS-1:0]  id_idx;
    logic [HIST_BITS-1:0] if_hist;
    logic [CTR_BITS-1:0]  if_ctr;
    logic [HIST_BITS-1:0] id_hist;
    logic [CTR_BITS-1:0]  id_ctr;
    logic [CTR_BITS-1:0]  ctr_next;
    logic [HIST_BITS-1:0] hist_next;
    logic                 clr_in_bht;
    logic                 clr_in_pht;

    assign if_idx = IF_PC[IDX_BITS+1:2];
    assign id_idx = ID_PC[IDX_BITS+1:2];

    // Only the index bits of the PCs are meaningful; no tags are kept.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[31:IDX_BITS+2], IF_PC[1:0],
                              ID_PC[31:IDX_BITS+2], ID_PC[1:0]};

    // Both lookups read the tables as they stand before this edge's update,
    // so an IF read colliding with an ID write sees the old value.
    always_comb begin
        if_hist = bht[if_idx];
        if_ctr  = pht[if_hist];
        id_hist = bht[id_idx];
        id_ctr  = pht[id_hist];

        ctr_next = id_ctr;
        if (Is_Taken) begin
            if (id_ctr != CTR_MAX) ctr_next = id_ctr + 1'b1;
        end else begin
            if (id_ctr != '0) ctr_next = id_ctr - 1'b1;
        end

        // Shift the new outcome in at the MSB; written this way it also
        // holds for a 1-bit history.
        hist_next = HIST_BITS'({Is_Taken, id_hist} >> 1);
    end

    assign clr_in_bht = (32'(clr) < BHT_DEPTH_U);
    assign clr_in_pht = (32'(clr) < PHT_DEPTH_U);

    // Control FSM: clear walk, then prediction.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= INIT;
            clr   <= '0;
            pred  <= 1'b0;
            Ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    pred <= 1'b0;
                    clr  <= clr + 1'b1;
                    // CLR_DEPTH is a power of two, so the last entry is all ones.
                    if (&clr) begin
                        state <= RUN;
                        Ready <= 1'b1;
                    end
                end
                RUN: begin
                    pred <= if_ctr[CTR_BITS-1];
                end
                default: begin
                    state <= INIT;
                    clr   <= '0;
                    pred  <= 1'b0;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

    // Table storage: one entry per table written per cycle, either by the
    // clear walk or by a qualified ID update. Nothing is written in reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (state == INIT) begin
                if (clr_in_bht) bht[clr[IDX_BITS-1:0]]  <= '0;
                if (clr_in_pht) pht[clr[HIST_BITS-1:0]] <= CTR_INIT;
            end else if (Is_Branch) begin
                pht[id_hist] <= ctr_next;
                bht[id_idx]  <= hist_next;
            end
        end
    end

endmodule

// File: tb/tb_lbp_param.sv
module tb_lbp_param;

    logic        CLK;
    logic        RESET;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic        Is_Branch;
    logic        Is_Taken;
    logic        pred;
    logic        Ready;

    logic        s_RESET;
    logic [31:0] s_IF_PC;
    logic [31:0] s_ID_PC;
    logic        s_Is_Branch;
    logic        s_Is_Taken;
    logic        s_pred;
    logic        s_Ready;

    int errors = 0;
    int checks = 0;
    int bad;

    lbp_param dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IF_PC     (IF_PC),
        .ID_PC     (ID_PC),
        .Is_Branch (Is_Branch),
        .Is_Taken  (Is_Taken),
        .pred      (pred),
        .Ready     (Ready)
    );

    lbp_param #(.HIST_BITS(4), .IDX_BITS(6), .CTR_BITS(3)) dut_s (
        .CLK       (CLK),
        .RESET     (s_RESET),
        .IF_PC     (s_IF_PC),
        .ID_PC     (s_ID_PC),
        .Is_Branch (s_Is_Branch),
        .Is_Taken  (s_Is_Taken),
        .pred      (s_pred),
        .Ready     (s_Ready)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_pred(input string name, input logic want);
        checks++;
        if (pred !== want) begin
            errors++;
            $display("FAIL %s: pred=%b expected %b", name, pred, want);
        end
    endtask

    // 1023 edges with Ready/pred low, Ready high on edge 1024.
    task automatic walk_default(input string name);
        bad = 0;
        repeat (1023) begin
            tick;
            if (Ready !== 1'b0 || pred !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s_early: %0d edges with Ready/pred set, expected 0", name, bad);
        end
        tick;
        checks++;
        if (Ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: Ready=%b expected 1", name, Ready);
        end
        check_pred({name, "_pred"}, 1'b0);
    endtask

    task automatic test_reset;
        // Branch updates are driven throughout the walk and must be ignored.
        RESET = 1'b0; Is_Branch = 1'b1; Is_Taken = 1'b1;
        ID_PC = 32'h0040_0010; IF_PC = 32'h0040_0010;
        repeat (3) tick;
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: Ready=%b expected 0", Ready);
        end
        check_pred("reset_pred", 1'b0);
        RESET = 1'b1;
        bad = 0;
        repeat (499) begin
            tick;
            if (Ready !== 1'b0 || pred !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL partial_walk: %0d edges with Ready/pred set, expected 0", bad);
        end
        RESET = 1'b0;
        tick;
        checks++;
        if (Ready !== 1'b0) begin
            errors++;
            $display("FAIL restart_ready: Ready=%b expected 0", Ready);
        end
        RESET = 1'b1;
        walk_default("restart_walk");
    endtask

    // 11 taken updates at index 4; the IF lookup of the same PC runs alongside,
    // so the 11th edge is the collision with PHT[0x3FF] going 1->2.
    task automatic test_always_taken;
        IF_PC = 32'h0040_0010; ID_PC = 32'h0040_0010;
        Is_Branch = 1'b1; Is_Taken = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            check_pred($sformatf("train_%0d", k), 1'b0);
        end
        Is_Branch = 1'b0;
        tick;
        check_pred("trained", 1'b1);
    endtask

    // Counter 2 -> 3 then held at 3; a wrap would drop the MSB.
    task automatic test_saturation;
        Is_Branch = 1'b1; Is_Taken = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            check_pred($sformatf("sat_up_%0d", k), 1'b1);
        end
        Is_Branch = 1'b0;
        tick;
        check_pred("sat_up_idle", 1'b1);
    endtask

    task automatic test_qualifier;
        Is_Branch = 1'b0; Is_Taken = 1'b1;
        bad = 0;
        repeat (20) begin
            tick;
            if (pred !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL qual_taken: %0d cycles pred=0, expected 0", bad);
        end
        Is_Taken = 1'b0;
        bad = 0;
        repeat (20) begin
            tick;
            if (pred !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL qual_not_taken: %0d cycles pred=0, expected 0", bad);
        end
    endtask

    // 0x00401010 shares BHT index 4: a not-taken update there moves the
    // history seen by 0x00400010 to 0x1FF, an untrained counter.
    task automatic test_aliasing;
        IF_PC = 32'h0040_0010; ID_PC = 32'h0040_1010;
        Is_Branch = 1'b1; Is_Taken = 1'b0;
        tick;
        check_pred("alias_collide", 1'b1);
        Is_Branch = 1'b0;
        tick;
        check_pred("alias_moved", 1'b0);
    endtask

    // Fresh tables: two not-taken at history 0 leave PHT[0]=0, then two
    // taken updates from other zero-history entries bring it to 2.
    task automatic test_zero_saturation;
        RESET = 1'b0; Is_Branch = 1'b0;
        repeat (2) tick;
        RESET = 1'b1;
        walk_default("fresh_walk");
        IF_PC = 32'h0040_001C; ID_PC = 32'h0040_0010;
        Is_Branch = 1'b1; Is_Taken = 1'b0;
        tick;
        check_pred("nt_1", 1'b0);
        tick;
        check_pred("nt_2", 1'b0);
        Is_Branch = 1'b0;
        tick;
        check_pred("floor_held", 1'b0);
        ID_PC = 32'h0040_0014; Is_Branch = 1'b1; Is_Taken = 1'b1;
        tick;
        Is_Branch = 1'b0;
        tick;
        check_pred("floor_plus1", 1'b0);
        ID_PC = 32'h0040_0018; Is_Branch = 1'b1;
        tick;
        Is_Branch = 1'b0;
        tick;
        check_pred("floor_plus2", 1'b1);
    endtask

    // HIST_BITS=4, IDX_BITS=6, CTR_BITS=3: 64-edge walk, counters start at 3.
    task automatic test_small_params;
        s_RESET = 1'b0;
        repeat (2) tick;
        s_RESET = 1'b1;
        bad = 0;
        repeat (63) begin
            tick;
            if (s_Ready !== 1'b0 || s_pred !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL small_walk_early: %0d edges with Ready/pred set, expected 0", bad);
        end
        tick;
        checks++;
        if (s_Ready !== 1'b1) begin
            errors++;
            $display("FAIL small_ready: Ready=%b expected 1", s_Ready);
        end
        s_IF_PC = 32'h0040_0010; s_ID_PC = 32'h0040_0010;
        s_Is_Branch = 1'b1; s_Is_Taken = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            checks++;
            if (s_pred !== 1'b0) begin
                errors++;
                $display("FAIL small_fill_%0d: pred=%b expected 0", k, s_pred);
            end
        end
        s_Is_Branch = 1'b0;
        tick;
        checks++;
        if (s_pred !== 1'b0) begin
            errors++;
            $display("FAIL small_filled: pred=%b expected 0", s_pred);
        end
        s_Is_Branch = 1'b1;
        tick;
        checks++;
        if (s_pred !== 1'b0) begin
            errors++;
            $display("FAIL small_train: pred=%b expected 0", s_pred);
        end
        s_Is_Branch = 1'b0;
        tick;
        checks++;
        if (s_pred !== 1'b1) begin
            errors++;
            $display("FAIL small_trained: pred=%b expected 1", s_pred);
        end
    endtask

    initial begin
        RESET = 1'b0; IF_PC = '0; ID_PC = '0; Is_Branch = 1'b0; Is_Taken = 1'b0;
        s_RESET = 1'b0; s_IF_PC = '0; s_ID_PC = '0; s_Is_Branch = 1'b0; s_Is_Taken = 1'b0;
        test_reset;
        test_always_taken;
        test_saturation;
        test_qualifier;
        test_aliasing;
        test_zero_saturation;
        test_small_params;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
